// File: rtl/irq_pkg.sv
// Shared constants for the external interrupt controller: default bus window
// base address and the word offsets of the four registers inside it.
package irq_pkg;

    localparam logic [31:0] BASE     = 32'h0000_7F20;

    localparam logic [1:0]  OFF_ACK  = 2'd0;
    localparam logic [1:0]  OFF_MASK = 2'd1;
    localparam logic [1:0]  OFF_MODE = 2'd2;
    localparam logic [1:0]  OFF_ID   = 2'd3;

endpackage

// File: rtl/irq_sync_edge.sv
// Per-source two-flop synchroniser followed by an edge flop. Produces the
// synchronised level (s2) and a one-cycle rising-edge strobe (s2 & ~s3).
module irq_sync_edge (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_src,
    output logic o_s2,
    output logic o_rise
);

    logic r_s1;
    logic r_s2;
    logic r_s3;

    // Shift the raw source through s1/s2 for metastability, s3 remembers last s2
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= i_src;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign o_s2   = r_s2;
    assign o_rise = r_s2 & ~r_s3;

endmodule

// File: rtl/irq_ctrl.sv
// Memory-mapped external interrupt controller. Synchronises NSRC sources,
// qualifies each as level-high or rising-edge, latches pending bits, masks
// them and reports the lowest-index enabled pending source to the CPU.
module irq_ctrl #(
    parameter int          NSRC = 4,
    parameter logic [31:0] BASE = irq_pkg::BASE,
    parameter int          IDW  = 3
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NSRC-1:0] src_in,
    input  logic [31:0]     m_addr,
    input  logic [31:0]     m_wdata,
    input  logic [3:0]      m_byteen,
    output logic [31:0]     m_rdata,
    output logic            irq_out,
    output logic [IDW-1:0]  irq_id
);

    import irq_pkg::*;

    logic [NSRC-1:0] r_pending;
    logic [NSRC-1:0] r_mask;
    logic [NSRC-1:0] r_mode;
    logic            r_irq_out;
    logic [IDW-1:0]  r_irq_id;

    logic [NSRC-1:0] w_s2;
    logic [NSRC-1:0] w_rise;
    logic [NSRC-1:0] w_set;
    logic [NSRC-1:0] w_clr;
    logic [NSRC-1:0] w_req;
    logic [IDW-1:0]  w_req_idx;
    logic            w_hit;
    logic [1:0]      w_off;
    logic            w_wr;
    logic [NSRC-1:0] w_ack_field;
    logic [31:0]     w_unused_wdata;

    // Lowest set bit of a request vector wins.
    function automatic logic [IDW-1:0] prio_enc(input logic [NSRC-1:0] req);
        logic [IDW-1:0] idx;
        idx = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (req[i]) idx = IDW'(i);
        end
        return idx;
    endfunction

    // Expand a source id into a single-bit clear vector.
    function automatic logic [NSRC-1:0] onehot(input logic [IDW-1:0] id);
        logic [NSRC-1:0] vec;
        for (int i = 0; i < NSRC; i++) begin
            vec[i] = (id == IDW'(i));
        end
        return vec;
    endfunction

    genvar g;
    generate
        for (g = 0; g < NSRC; g++) begin : g_src
            irq_sync_edge u_sync (
                .i_clk   (clk),
                .i_rst_n (reset),
                .i_src   (src_in[g]),
                .o_s2    (w_s2[g]),
                .o_rise  (w_rise[g])
            );
        end
    endgenerate

    assign w_hit          = (m_addr & ~32'hF) == BASE;
    assign w_off          = m_addr[3:2];
    assign w_wr           = w_hit && (|m_byteen);
    assign w_ack_field    = m_wdata[NSRC-1:0];
    assign w_unused_wdata = m_wdata;

    assign w_set     = (r_mode & w_rise) | (~r_mode & w_s2);
    assign w_req     = r_pending & r_mask;
    assign w_req_idx = prio_enc(w_req);

    // Ack clear vector: explicit bits if given, otherwise the reported source
    always_comb begin
        w_clr = '0;
        if (w_wr && (w_off == OFF_ACK)) begin
            if (w_ack_field != '0) begin
                w_clr = w_ack_field;
            end else if (r_irq_out) begin
                w_clr = onehot(r_irq_id);
            end
        end
    end

    // Pending latch; a set in the same cycle as its clear keeps the bit
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pending <= '0;
        end else begin
            r_pending <= (r_pending & ~w_clr) | w_set;
        end
    end

    // MASK and MODE registers, written only through the low byte lane
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_mask <= '1;
            r_mode <= '0;
        end else if (w_wr && m_byteen[0]) begin
            if (w_off == OFF_MASK) r_mask <= w_ack_field;
            if (w_off == OFF_MODE) r_mode <= w_ack_field;
        end
    end

    // Registered request and id; id holds its last value when nothing is requested
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_irq_out <= 1'b0;
            r_irq_id  <= '0;
        end else begin
            r_irq_out <= |w_req;
            if (|w_req) r_irq_id <= w_req_idx;
        end
    end

    // Combinational read mux; reads outside the window return zero
    always_comb begin
        m_rdata = 32'h0;
        if (w_hit) begin
            case (w_off)
                OFF_ACK:  m_rdata = 32'(r_pending);
                OFF_MASK: m_rdata = 32'(r_mask);
                OFF_MODE: m_rdata = 32'(r_mode);
                OFF_ID:   m_rdata = {r_irq_out, 28'b0, 3'(r_irq_id)};
                default:  m_rdata = 32'h0;
            endcase
        end
    end

    assign irq_out = r_irq_out;
    assign irq_id  = r_irq_id;

endmodule
